// File: rtl/button_command_gen_pkg.sv
// button_command_gen_pkg: button indices, horizontal FSM states, command bundle and timing defaults
package button_command_gen_pkg;
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int DAS_DELAY_DEF   = 16;
    localparam int ARR_PERIOD_DEF  = 6;
    localparam int DROP_PERIOD_DEF = 2;
    typedef enum logic [2:0] {
        H_IDLE, H_DELAY_L, H_REPEAT_L, H_DELAY_R, H_REPEAT_R
    } h_state_e;
    typedef struct packed {
        logic pause_toggle;
        logic hard_drop;
        logic soft_drop;
        logic rotate_ccw;
        logic rotate_cw;
        logic move_right;
        logic move_left;
    } cmd_t;
    function automatic logic rose(input logic [7:0] now, input logic [7:0] prev, input int idx);
        return now[idx] & ~prev[idx];
    endfunction
endpackage

// File: rtl/button_command_gen_if.sv
// button_command_gen_if: poll-frame input and command-pulse output bundle
interface button_command_gen_if;
    logic [7:0] btn_raw_n;
    logic       btn_valid;
    logic       game_active;
    logic       move_left;
    logic       move_right;
    logic       rotate_cw;
    logic       rotate_ccw;
    logic       soft_drop;
    logic       hard_drop;
    logic       pause_toggle;
    logic [7:0] buttons_held;
    modport master (
        output btn_raw_n, btn_valid, game_active,
        input  move_left, move_right, rotate_cw, rotate_ccw, soft_drop, hard_drop, pause_toggle, buttons_held
    );
    modport slave (
        input  btn_raw_n, btn_valid, game_active,
        output move_left, move_right, rotate_cw, rotate_ccw, soft_drop, hard_drop, pause_toggle, buttons_held
    );
endinterface

// File: rtl/button_command_gen_repeat_counter.sv
// button_command_gen_repeat_counter: frame-driven down-counter that fires on 1 -> 0 and reloads
module button_command_gen_repeat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] load_val_i,
    input  logic [W-1:0] reload_val_i,
    output logic         fire_o
);
    logic [W-1:0] cnt_q, cnt_d;
    assign fire_o = dec_i & (cnt_q == W'(1));
    // A zero count stays parked: holding a button without a fresh press never fires
    always_comb
        cnt_d = clear_i ? '0 :
                load_i ? load_val_i :
                fire_o ? reload_val_i :
                (dec_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/button_command_gen.sv
// button_command_gen: turns NES poll frames into one-clk Tetris command pulses
// with edge detection, left/right DAS auto-repeat and soft-drop repeat.
module button_command_gen
    import button_command_gen_pkg::*;
#(
    parameter int DAS_DELAY   = DAS_DELAY_DEF,
    parameter int ARR_PERIOD  = ARR_PERIOD_DEF,
    parameter int DROP_PERIOD = DROP_PERIOD_DEF
) (
    input logic clk,
    input logic reset,
    button_command_gen_if.slave bus
);
    localparam int HW = $clog2(DAS_DELAY > ARR_PERIOD ? DAS_DELAY : ARR_PERIOD) + 1;
    localparam int DW = $clog2(DROP_PERIOD) + 1;
    logic [7:0] pressed, held_q, held_d;
    h_state_e   state_q, state_d;
    cmd_t       cmd_q, cmd_d;
    logic frame, eff_l, eff_r, eff_l_rise, eff_r_rise, in_l, in_r, up_rise, down_rise;
    logic h_load, h_dec, h_clear, h_fire, d_load, d_dec, d_clear, d_fire;
    assign pressed    = ~bus.btn_raw_n;
    assign frame      = bus.btn_valid & bus.game_active;
    assign eff_l      = pressed[BTN_LEFT] & ~pressed[BTN_RIGHT];
    assign eff_r      = pressed[BTN_RIGHT] & ~pressed[BTN_LEFT];
    assign eff_l_rise = eff_l & ~(held_q[BTN_LEFT] & ~held_q[BTN_RIGHT]);
    assign eff_r_rise = eff_r & ~(held_q[BTN_RIGHT] & ~held_q[BTN_LEFT]);
    assign in_l       = state_q inside {H_DELAY_L, H_REPEAT_L};
    assign in_r       = state_q inside {H_DELAY_R, H_REPEAT_R};
    assign up_rise    = rose(pressed, held_q, BTN_UP);
    assign down_rise  = rose(pressed, held_q, BTN_DOWN);
    assign h_load  = frame & (eff_l_rise | eff_r_rise);
    assign h_dec   = frame & ((eff_l & ~eff_l_rise & in_l) | (eff_r & ~eff_r_rise & in_r));
    assign h_clear = ~bus.game_active | (bus.btn_valid & ~h_load & ~h_dec);
    // Up and Down rising together is a hard drop; soft-drop repeat waits for a fresh Down press
    assign d_load  = frame & down_rise & ~up_rise;
    assign d_dec   = frame & pressed[BTN_DOWN] & ~down_rise;
    assign d_clear = ~bus.game_active | (bus.btn_valid & ~d_load & ~d_dec);
    button_command_gen_repeat_counter #(.W(HW)) u_h_cnt (
        .clk(clk), .reset(reset), .clear_i(h_clear), .load_i(h_load), .dec_i(h_dec),
        .load_val_i(HW'(DAS_DELAY)), .reload_val_i(HW'(ARR_PERIOD)), .fire_o(h_fire)
    );
    button_command_gen_repeat_counter #(.W(DW)) u_d_cnt (
        .clk(clk), .reset(reset), .clear_i(d_clear), .load_i(d_load), .dec_i(d_dec),
        .load_val_i(DW'(DROP_PERIOD)), .reload_val_i(DW'(DROP_PERIOD)), .fire_o(d_fire)
    );
    always_comb begin
        state_d = h_clear ? H_IDLE :
                  h_load ? (eff_l_rise ? H_DELAY_L : H_DELAY_R) :
                  h_fire ? (eff_l ? H_REPEAT_L : H_REPEAT_R) : state_q;
        held_d = bus.btn_valid ? pressed : held_q;
        cmd_d = '0;
        cmd_d.move_left    = (h_load & eff_l_rise) | (h_fire & eff_l);
        cmd_d.move_right   = (h_load & eff_r_rise) | (h_fire & eff_r);
        cmd_d.rotate_cw    = frame & rose(pressed, held_q, BTN_A);
        cmd_d.rotate_ccw   = frame & rose(pressed, held_q, BTN_B);
        cmd_d.soft_drop    = d_load | d_fire;
        cmd_d.hard_drop    = frame & up_rise;
        cmd_d.pause_toggle = bus.btn_valid & rose(pressed, held_q, BTN_START);
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= H_IDLE;
            held_q  <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            cmd_q   <= cmd_d;
        end
    assign bus.move_left    = cmd_q.move_left;
    assign bus.move_right   = cmd_q.move_right;
    assign bus.rotate_cw    = cmd_q.rotate_cw;
    assign bus.rotate_ccw   = cmd_q.rotate_ccw;
    assign bus.soft_drop    = cmd_q.soft_drop;
    assign bus.hard_drop    = cmd_q.hard_drop;
    assign bus.pause_toggle = cmd_q.pause_toggle;
    assign bus.buttons_held = held_q;
endmodule

// File: tb/tb_button_command_gen.sv
// tb_button_command_gen: directed poll-frame sequences with hand-computed command pulses
module tb_button_command_gen;
    localparam logic [7:0] A = 8'h01, B = 8'h02, SEL = 8'h04, ST = 8'h08;
    localparam logic [7:0] UP = 8'h10, DN = 8'h20, LF = 8'h40, RT = 8'h80;
    localparam logic [6:0] NONE = 7'h00, ML = 7'h01, MR = 7'h02, CW = 7'h04, CCW = 7'h08;
    localparam logic [6:0] SD = 7'h10, HD = 7'h20, PS = 7'h40;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [6:0] cmd;
    button_command_gen_if bus();
    button_command_gen dut (.clk(clk), .reset(reset), .bus(bus));
    always #10 clk = ~clk;
    assign cmd = {bus.pause_toggle, bus.hard_drop, bus.soft_drop, bus.rotate_ccw,
                  bus.rotate_cw, bus.move_right, bus.move_left};
    task automatic chk(input logic [7:0] got, input logic [7:0] exp, input string tag);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask
    // One poll: a valid frame, the pulse on the next clk, then all pulses low one clk later
    task automatic poll(input logic [7:0] p, input logic [6:0] exp, input string tag);
        @(negedge clk);
        bus.btn_raw_n = ~p;
        bus.btn_valid = 1'b1;
        @(posedge clk);
        #1;
        chk({1'b0, cmd}, {1'b0, exp}, tag);
        chk(bus.buttons_held, p, {tag, "_held"});
        bus.btn_valid = 1'b0;
        bus.btn_raw_n = 8'($urandom);
        @(posedge clk);
        #1;
        chk({1'b0, cmd}, 8'h00, {tag, "_width"});
    endtask
    initial begin
        bus.btn_raw_n   = 8'hFF;
        bus.btn_valid   = 1'b0;
        bus.game_active = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk({1'b0, cmd}, 8'h00, "reset_cmd");
        chk(bus.buttons_held, 8'h00, "reset_held");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 40; i++)
            poll(LF, (i == 0 || i == 16 || i == 22 || i == 28 || i == 34) ? ML : NONE, $sformatf("das_%0d", i));
        poll(8'h00, NONE, "das_release");
        for (int i = 0; i < 22; i++)
            poll(LF, (i == 0 || i == 16) ? ML : NONE, $sformatf("rst_hold_%0d", i));
        @(negedge clk);
        bus.btn_raw_n = ~LF;
        bus.btn_valid = 1'b1;
        @(posedge clk);
        #1;
        chk({1'b0, cmd}, {1'b0, ML}, "rst_repeat_pulse");
        bus.btn_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk({1'b0, cmd}, 8'h00, "rst_async_cmd");
        chk(bus.buttons_held, 8'h00, "rst_async_held");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        poll(LF, ML, "rst_fresh_press");
        poll(LF, NONE, "rst_fresh_hold");
        poll(8'h00, NONE, "rst_release");
        poll(LF, ML, "cf_0");
        poll(LF, NONE, "cf_1");
        poll(LF, NONE, "cf_2");
        poll(LF | RT, NONE, "cf_3");
        poll(LF | RT, NONE, "cf_4");
        for (int i = 5; i < 22; i++)
            poll(RT, (i == 5 || i == 21) ? MR : NONE, $sformatf("cf_%0d", i));
        poll(LF, ML, "cf_switch_left");
        poll(8'h00, NONE, "cf_release");
        for (int i = 0; i < 7; i++)
            poll(DN, (i % 2 == 0) ? SD : NONE, $sformatf("drop_%0d", i));
        poll(8'h00, NONE, "drop_release");
        poll(UP | DN, HD, "updown_rise");
        for (int i = 0; i < 3; i++)
            poll(UP | DN, NONE, $sformatf("updown_hold_%0d", i));
        poll(8'h00, NONE, "updown_release");
        poll(A | B | ST, CW | CCW | PS, "edges_rise");
        for (int i = 0; i < 10; i++)
            poll(A | B | ST, NONE, $sformatf("edges_hold_%0d", i));
        poll(SEL, NONE, "select_only");
        poll(A | LF | ST, CW | ML | PS, "multi_rise");
        poll(8'h00, NONE, "multi_release");
        bus.game_active = 1'b0;
        poll(A | LF, NONE, "gate_off_0");
        poll(A | LF | ST, PS, "gate_off_start");
        poll(A | LF | DN | UP, NONE, "gate_off_drop");
        poll(A | LF, NONE, "gate_off_1");
        bus.game_active = 1'b1;
        for (int i = 0; i < 3; i++)
            poll(A | LF, NONE, $sformatf("gate_on_held_%0d", i));
        poll(8'h00, NONE, "gate_on_release");
        poll(A | LF, CW | ML, "gate_on_repress");
        poll(8'h00, NONE, "final_release");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
